apb_master_bridge: RTL

- Upstream neighbour of the generated APB register blocks: converts a simple valid/ready command/response host channel into APB4 master transfers that drive the register block's APB slave port.
- Exactly one outstanding transfer; programmable timeout protects against a slave that never asserts pready.
- Used by CPU-side glue and test harnesses to reach register maps without native APB.

---
 rtl/apb_master_bridge.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// APB4 master bridge: turns a valid/ready command/response channel into
// single outstanding APB transfers, with an optional pready timeout.
module apb_master_bridge #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_cmd_address,
    input  logic [DATA_WIDTH-1:0]     i_cmd_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_WIDTH-1:0]     o_rsp_read_data,
    output logic                      o_rsp_error,
    output logic                      o_rsp_timeout,
    output logic                      o_psel,
    output logic                      o_penable,
    output logic                      o_pwrite,
    output logic [ADDRESS_WIDTH-1:0]  o_paddr,
    output logic [2:0]                o_pprot,
    output logic [DATA_WIDTH-1:0]     o_pwdata,
    output logic [DATA_WIDTH/8-1:0]   o_pstrb,
    input  logic                      i_pready,
    input  logic [DATA_WIDTH-1:0]     i_prdata,
    input  logic                      i_pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LIM_INT    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LIM_INT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_error_q, rsp_error_d;
    logic                     rsp_timeout_q, rsp_timeout_d;
    logic                     psel_q, psel_d;
    logic                     penable_q, penable_d;
    logic                     pwrite_q, pwrite_d;
    logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]    pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]    pstrb_q, pstrb_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    state_d     = S_SETUP;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = i_cmd_write;
                    paddr_d     = {i_cmd_address[ADDRESS_WIDTH-1:LSB], LSB'(0)};
                    pwdata_d    = i_cmd_write ? i_cmd_write_data : '0;
                    pstrb_d     = i_cmd_write ? i_cmd_strobe : '0;
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                // pready is checked first so it wins over a same-cycle timeout
                if (i_pready) begin
                    state_d       = S_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : i_prdata;
                    rsp_error_d   = i_pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (TIMEOUT_CYCLES > 0) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LIM) begin
                        state_d       = S_RESP;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
        end
    end

    assign o_cmd_ready     = cmd_ready_q;
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_read_data = rsp_rdata_q;
    assign o_rsp_error     = rsp_error_q;
    assign o_rsp_timeout   = rsp_timeout_q;
    assign o_psel          = psel_q;
    assign o_penable       = penable_q;
    assign o_pwrite        = pwrite_q;
    assign o_paddr         = paddr_q;
    assign o_pprot         = 3'b000;
    assign o_pwdata        = pwdata_q;
    assign o_pstrb         = pstrb_q;

endmodule
